mux_scan_n: RTL and testbench

Parametrised N-channel, W-bit registered multiplexer with two modes: manual selection from an external select bus and automatic round-robin scanning with a programmable dwell time per channel. It generalises the 4:1 × 2-bit combinational multiplexer. It adds a registered output, a valid flag, the channel index, a hold/freeze control and a wrap pulse. It sits between a bank of parallel data sources and a single display or serial consumer.

---
 rtl/mux_scan_n.sv | 128 ++++++++++++
 tb/tb_mux_scan_n.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/mux_scan_n.sv
// rtl/mux_scan_n.sv - N-channel registered mux with manual select and dwell-timed round-robin scan
module mux_scan_n #(
    parameter int W     = 2,
    parameter int N     = 4,
    parameter int SW    = $clog2(N),
    parameter int DWELL = 4
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic [N*W-1:0]    i_din,
    input  logic              i_en,
    input  logic              i_mode,
    input  logic [SW-1:0]     i_sel,
    input  logic              i_hold,
    output logic [W-1:0]      o_mux_out,
    output logic [SW-1:0]     o_ch_out,
    output logic              o_valid,
    output logic              o_wrap
);

    localparam int            CW       = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DWELL - 1);
    localparam logic [SW-1:0] CH_LAST  = SW'(N - 1);
    localparam logic [SW:0]   N_EXT    = (SW + 1)'(N);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_MANUAL = 2'd1,
        S_SCAN   = 2'd2
    } state_t;

    state_t        r_state;
    state_t        w_state_nxt;
    logic [CW-1:0] r_cnt;
    logic [CW-1:0] w_cnt_nxt;
    logic [SW-1:0] w_ch_nxt;
    logic [SW-1:0] w_ch_inc;
    logic [W-1:0]  w_mux_nxt;
    logic [W-1:0]  w_src_data;
    logic          w_valid_nxt;
    logic          w_wrap_nxt;
    logic          w_sel_ok;

    // Out-of-range selects only exist when N is not a power of two.
    generate
        if (N == (1 << SW)) begin : g_sel_full
            assign w_sel_ok = 1'b1;
        end else begin : g_sel_part
            assign w_sel_ok = ({1'b0, i_sel} < N_EXT);
        end
    endgenerate

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = S_IDLE;
        if (i_en) begin
            w_state_nxt = i_mode ? S_SCAN : S_MANUAL;
        end
    end

    always_comb begin
        w_ch_inc = (o_ch_out == CH_LAST) ? '0 : o_ch_out + 1'b1;
    end

    always_comb begin
        w_ch_nxt    = o_ch_out;
        w_cnt_nxt   = '0;
        w_valid_nxt = 1'b0;
        w_wrap_nxt  = 1'b0;
        case (w_state_nxt)
            S_MANUAL: begin
                w_valid_nxt = 1'b1;
                if (w_sel_ok) begin
                    w_ch_nxt = i_sel;
                end
            end
            S_SCAN: begin
                w_valid_nxt = 1'b1;
                if (r_state != S_SCAN) begin
                    w_ch_nxt = '0;
                end else if (i_hold) begin
                    w_cnt_nxt = r_cnt;
                end else if (r_cnt != CNT_LAST) begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end else begin
                    w_ch_nxt   = w_ch_inc;
                    w_wrap_nxt = (o_ch_out == CH_LAST);
                end
            end
            default: ;
        endcase
    end

    // The output always shows live data of whichever channel is selected next.
    always_comb begin
        w_src_data = '0;
        for (int k = 0; k < N; k++) begin
            if (w_ch_nxt == SW'(k)) begin
                w_src_data = i_din[k*W +: W];
            end
        end
        w_mux_nxt = (w_state_nxt == S_IDLE) ? o_mux_out : w_src_data;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt     <= '0;
            o_mux_out <= '0;
            o_ch_out  <= '0;
            o_valid   <= 1'b0;
            o_wrap    <= 1'b0;
        end else begin
            r_cnt     <= w_cnt_nxt;
            o_mux_out <= w_mux_nxt;
            o_ch_out  <= w_ch_nxt;
            o_valid   <= w_valid_nxt;
            o_wrap    <= w_wrap_nxt;
        end
    end

endmodule

// File: tb/tb_mux_scan_n.sv
// tb/tb_mux_scan_n.sv - self-checking bench for mux_scan_n (N=4/DWELL=4 and N=3/DWELL=1 instances)
module tb_mux_scan_n;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] din0;
    logic       en0, mode0, hold0;
    logic [1:0] sel0;
    logic [1:0] mux0, ch0;
    logic       valid0, wrap0;
    logic [5:0] din1;
    logic       en1, mode1, hold1;
    logic [1:0] sel1;
    logic [1:0] mux1, ch1;
    logic       valid1, wrap1;

    int n_checks = 0;
    int n_errors = 0;

    // Model: per instance, phase (0 idle, 1 manual, 2 scan), active scan cycles since entry.
    int m_st[2];
    int m_a[2];
    int m_ch[2];
    int m_mux[2];
    int m_valid[2];
    int m_wrap[2];

    int exp_scan[17] = '{0, 0, 0, 0, 1, 1, 1, 1, 2, 2, 2, 2, 3, 3, 3, 3, 0};
    int exp_rst[5]   = '{0, 0, 0, 0, 1};
    int exp_odd[4]   = '{0, 1, 2, 0};

    always #5 clk = ~clk;

    mux_scan_n #(.W(2), .N(4), .DWELL(4)) u_dut0 (
        .i_clk(clk), .i_rst_n(rst_n), .i_din(din0), .i_en(en0), .i_mode(mode0),
        .i_sel(sel0), .i_hold(hold0), .o_mux_out(mux0), .o_ch_out(ch0),
        .o_valid(valid0), .o_wrap(wrap0)
    );

    mux_scan_n #(.W(2), .N(3), .DWELL(1)) u_dut1 (
        .i_clk(clk), .i_rst_n(rst_n), .i_din(din1), .i_en(en1), .i_mode(mode1),
        .i_sel(sel1), .i_hold(hold1), .o_mux_out(mux1), .o_ch_out(ch1),
        .o_valid(valid1), .o_wrap(wrap1)
    );

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_step(input int i, input int n, input int d, input bit en,
                              input bit mode, input int sel, input bit hold,
                              input logic [7:0] din);
        if (!en) begin
            m_st[i]    = 0;
            m_valid[i] = 0;
            m_wrap[i]  = 0;
        end else if (!mode) begin
            m_st[i]    = 1;
            m_valid[i] = 1;
            m_wrap[i]  = 0;
            if (sel < n) m_ch[i] = sel;
            m_mux[i] = int'((din >> (2 * m_ch[i])) & 8'd3);
        end else begin
            m_valid[i] = 1;
            if (m_st[i] != 2) begin
                m_a[i]    = 0;
                m_wrap[i] = 0;
            end else if (hold) begin
                m_wrap[i] = 0;
            end else begin
                m_a[i]    = m_a[i] + 1;
                m_wrap[i] = ((m_a[i] % (n * d)) == 0) ? 1 : 0;
            end
            m_ch[i]  = (m_a[i] / d) % n;
            m_mux[i] = int'((din >> (2 * m_ch[i])) & 8'd3);
            m_st[i]  = 2;
        end
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 2; i++) begin
                m_st[i] = 0; m_a[i] = 0; m_ch[i] = 0;
                m_mux[i] = 0; m_valid[i] = 0; m_wrap[i] = 0;
            end
        end else begin
            model_step(0, 4, 4, en0, mode0, int'(sel0), hold0, din0);
            model_step(1, 3, 1, en1, mode1, int'(sel1), hold1, {2'b00, din1});
        end
    end

    always @(posedge clk) begin
        #1;
        chk("m0_mux",   int'(mux0),   m_mux[0]);
        chk("m0_ch",    int'(ch0),    m_ch[0]);
        chk("m0_valid", int'(valid0), m_valid[0]);
        chk("m0_wrap",  int'(wrap0),  m_wrap[0]);
        chk("m1_mux",   int'(mux1),   m_mux[1]);
        chk("m1_ch",    int'(ch1),    m_ch[1]);
        chk("m1_valid", int'(valid1), m_valid[1]);
        chk("m1_wrap",  int'(wrap1),  m_wrap[1]);
    end

    initial begin
        rst_n = 1'b1;
        en0 = 0; mode0 = 0; hold0 = 0; sel0 = 0; din0 = 8'b11_10_01_00;
        en1 = 0; mode1 = 0; hold1 = 0; sel1 = 0; din1 = 6'b10_01_00;
        #2 rst_n = 1'b0;
        #1;
        chk("rst_mux", int'(mux0), 0);
        chk("rst_ch", int'(ch0), 0);
        chk("rst_valid", int'(valid0), 0);
        chk("rst_wrap", int'(wrap0), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (5) begin
            @(posedge clk); #2;
            chk("idle_valid", int'(valid0), 0);
            chk("idle_mux", int'(mux0), 0);
        end

        // Manual select
        @(negedge clk); en0 = 1; mode0 = 0; sel0 = 2;
        @(posedge clk); #2;
        chk("man_mux2", int'(mux0), 2);
        chk("man_ch2", int'(ch0), 2);
        chk("man_valid", int'(valid0), 1);
        @(negedge clk); sel0 = 3;
        @(posedge clk); #2;
        chk("man_mux3", int'(mux0), 3);
        @(negedge clk); en0 = 0;
        @(posedge clk); #2;
        chk("off_valid", int'(valid0), 0);
        chk("off_mux_hold", int'(mux0), 3);

        // Full scan cycle
        @(negedge clk); en0 = 1; mode0 = 1; hold0 = 0;
        for (int k = 0; k < 17; k++) begin
            @(posedge clk); #2;
            chk("scan_ch", int'(ch0), exp_scan[k]);
            chk("scan_mux", int'(mux0), exp_scan[k]);
            chk("scan_wrap", int'(wrap0), (k == 16) ? 1 : 0);
        end
        @(posedge clk); #2;
        chk("wrap_single", int'(wrap0), 0);

        // Hold at channel 1, counter 2
        @(negedge clk); en0 = 0;
        @(negedge clk); en0 = 1; mode0 = 1;
        @(posedge clk);
        repeat (6) @(posedge clk);
        #2 chk("hold_pre_ch", int'(ch0), 1);
        @(negedge clk); hold0 = 1; din0 = 8'b11_10_00_00;
        repeat (10) begin
            @(posedge clk); #2;
            chk("hold_ch", int'(ch0), 1);
            chk("hold_mux", int'(mux0), 0);
        end
        @(negedge clk); hold0 = 0;
        @(posedge clk); #2;
        chk("rel_ch1", int'(ch0), 1);
        @(posedge clk); #2;
        chk("rel_ch2", int'(ch0), 2);
        chk("rel_mux2", int'(mux0), 2);

        // Asynchronous reset mid-scan
        @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("arst_mux", int'(mux0), 0);
        chk("arst_ch", int'(ch0), 0);
        chk("arst_valid", int'(valid0), 0);
        chk("arst_wrap", int'(wrap0), 0);
        #1 rst_n = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(posedge clk); #2;
            chk("arst_scan_ch", int'(ch0), exp_rst[k]);
            chk("arst_scan_valid", int'(valid0), 1);
        end

        // Odd N, DWELL=1 instance
        @(negedge clk); en0 = 0; en1 = 1; mode1 = 0; sel1 = 1;
        @(posedge clk); #2;
        chk("odd_ch1", int'(ch1), 1);
        chk("odd_mux1", int'(mux1), 1);
        @(negedge clk); sel1 = 3; din1 = 6'b10_11_00;
        @(posedge clk); #2;
        chk("odd_oor_ch", int'(ch1), 1);
        chk("odd_oor_mux", int'(mux1), 3);
        @(negedge clk); mode1 = 1; din1 = 6'b10_01_00;
        for (int k = 0; k < 4; k++) begin
            @(posedge clk); #2;
            chk("odd_scan_ch", int'(ch1), exp_odd[k]);
            chk("odd_scan_wrap", int'(wrap1), (k == 3) ? 1 : 0);
        end

        @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
